// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a
// time to instruction memory and queues returned words in a small in-order
// buffer whose head feeds the control decoder.
//
// state | meaning
// IDLE  | no request outstanding; waits for a free buffer slot
// REQ   | request for fpc outstanding; ack pushes the word
// DROP  | stale request still outstanding after a redirect; data discarded
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state, state_nx;
  logic [31:0]   fpc, fpc_nx;
  logic [31:0]   stale, stale_nx;
  logic [PW-1:0] rd_ptr, rd_ptr_nx;
  logic [PW-1:0] wr_ptr, wr_ptr_nx;
  logic [CW-1:0] count, count_nx;
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic          push, pop, flush;
  logic [31:0]   redir_pc;

  assign flush    = redirect_valid;
  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;
  // A pop coinciding with a flush is swallowed by the flush.
  assign pop      = out_valid && out_ready && !flush;

  // Next-state, fetch PC and buffer bookkeeping.
  always_comb begin
    state_nx  = state;
    fpc_nx    = fpc;
    stale_nx  = stale;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fpc_nx = redir_pc;
        end else if ((count - CW'(pop)) < FULL) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          fpc_nx = redir_pc;
          if (imem_ack) begin
            state_nx = REQ;
          end else begin
            stale_nx = fpc;
            state_nx = DROP;
          end
        end else if (imem_ack) begin
          push   = 1'b1;
          fpc_nx = fpc + 32'd4;
          if ((count + CW'(1) - CW'(pop)) < FULL) state_nx = REQ;
          else                                    state_nx = IDLE;
        end
      end
      DROP: begin
        if (redirect_valid) fpc_nx = redir_pc;
        if (imem_ack)       state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase

    if (flush) begin
      count_nx  = '0;
      rd_ptr_nx = '0;
      wr_ptr_nx = '0;
    end else begin
      count_nx  = count + CW'(push) - CW'(pop);
      rd_ptr_nx = rd_ptr + PW'(pop);
      wr_ptr_nx = wr_ptr + PW'(push);
    end
  end

  // State, PC and pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      stale  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nx;
      fpc    <= fpc_nx;
      stale  <= stale_nx;
      rd_ptr <= rd_ptr_nx;
      wr_ptr <= wr_ptr_nx;
      count  <= count_nx;
    end
  end

  // Buffer storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fpc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

  // Memory request and decoder-facing outputs.
  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = '0;
    if (state == REQ)  imem_addr = fpc;
    if (state == DROP) imem_addr = stale;
    out_valid = (count != '0);
    out_pc    = out_valid ? buf_pc[rd_ptr]    : 32'h0;
    out_instr = out_valid ? buf_instr[rd_ptr] : 32'h0;
    out_opcode = out_instr[6:0];
  end

endmodule
